// File: rtl/vram_arbiter_pkg.sv
// Shared types for the VRAM arbiter: owner tags, CPU FSM states, default sizing.
package vram_arbiter_pkg;

  localparam int unsigned ADDR_W_DEF     = 14;
  localparam int unsigned DATA_W_DEF     = 8;
  localparam int unsigned RD_LAT_DEF     = 1;
  localparam int unsigned STARVE_MAX_DEF = 4;
  localparam int unsigned STARVE_W       = 4;

  typedef enum logic {
    OWN_VID = 1'b0,
    OWN_CPU = 1'b1
  } owner_e;

  typedef enum logic [1:0] {
    C_IDLE = 2'd0,
    C_BUSY = 2'd1,
    C_ACK  = 2'd2
  } cpu_state_e;

  typedef struct packed {
    logic   valid;
    owner_e owner;
  } rd_tag_t;

  function automatic rd_tag_t make_tag(input logic valid, input owner_e owner);
    rd_tag_t t;
    t.valid = valid;
    t.owner = owner;
    return t;
  endfunction

endpackage

// File: rtl/vram_arbiter_if.sv
// CPU, video-fetch and VRAM-macro signals of the arbiter bundled as one interface.
interface vram_arbiter_if
  import vram_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_ack;
  logic              vid_req;
  logic [ADDR_W-1:0] vid_addr;
  logic              vid_gnt;
  logic [DATA_W-1:0] vid_rdata;
  logic              vid_valid;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  // Requesters and memory macro side
  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, vid_req, vid_addr, mem_rdata,
    input  cpu_rdata, cpu_ack, vid_gnt, vid_rdata, vid_valid,
           mem_en, mem_we, mem_addr, mem_wdata
  );

  // Arbiter side
  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, vid_req, vid_addr, mem_rdata,
    output cpu_rdata, cpu_ack, vid_gnt, vid_rdata, vid_valid,
           mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/vram_arbiter_rd_pipe.sv
// Read-tag delay line: carries {valid, owner} from grant to the cycle the read data returns.
module vram_rd_pipe
  import vram_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic    clk,
  input  logic    reset_n,
  input  rd_tag_t tag_in,
  output rd_tag_t tag_out
);

  rd_tag_t stage [DEPTH];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else begin
      stage[0] <= tag_in;
      for (int unsigned i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign tag_out = stage[DEPTH-1];

endmodule

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: video fetch has priority, a starvation counter
// guarantees CPU progress, read data returns in grant order tagged by owner.
module vram_arbiter
  import vram_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W     = ADDR_W_DEF,
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter int unsigned RD_LAT     = RD_LAT_DEF,
  parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
  input logic           clk,
  input logic           reset_n,
  vram_arbiter_if.slave bus
);

  localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

  cpu_state_e          state;
  logic [STARVE_W-1:0] starve_cnt;
  logic                cpu_elig;
  logic                cpu_gnt;
  logic                vid_win;
  rd_tag_t             tag_in;
  rd_tag_t             tag_out;
  logic                vid_ret;
  logic                cpu_ret;

  // Arbitration for the current cycle; CPU only eligible with no transaction outstanding
  always_comb begin
    cpu_elig = bus.cpu_req && (state == C_IDLE);
    cpu_gnt  = cpu_elig && (!bus.vid_req || (starve_cnt == STARVE_LIM));
    vid_win  = bus.vid_req && !cpu_gnt;
    tag_in   = make_tag((cpu_gnt && !bus.cpu_we) || vid_win, cpu_gnt ? OWN_CPU : OWN_VID);
    vid_ret  = tag_out.valid && (tag_out.owner == OWN_VID);
    cpu_ret  = tag_out.valid && (tag_out.owner == OWN_CPU);
  end

  assign bus.vid_gnt = vid_win;

  vram_rd_pipe #(.DEPTH(RD_LAT + 1)) u_rd_pipe (
    .clk     (clk),
    .reset_n (reset_n),
    .tag_in  (tag_in),
    .tag_out (tag_out)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state         <= C_IDLE;
      starve_cnt    <= '0;
      bus.mem_en    <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= {ADDR_W{1'b0}};
      bus.mem_wdata <= {DATA_W{1'b0}};
      bus.cpu_ack   <= 1'b0;
      bus.cpu_rdata <= {DATA_W{1'b0}};
      bus.vid_valid <= 1'b0;
      bus.vid_rdata <= {DATA_W{1'b0}};
    end else begin
      // Command register: one memory command per cycle from the winner
      bus.mem_en <= cpu_gnt || vid_win;
      bus.mem_we <= cpu_gnt && bus.cpu_we;
      if (cpu_gnt) begin
        bus.mem_addr  <= bus.cpu_addr;
        bus.mem_wdata <= bus.cpu_we ? bus.cpu_wdata : {DATA_W{1'b0}};
      end else if (vid_win) begin
        bus.mem_addr  <= bus.vid_addr;
        bus.mem_wdata <= {DATA_W{1'b0}};
      end

      if (cpu_elig && !cpu_gnt)
        starve_cnt <= (starve_cnt == STARVE_LIM) ? starve_cnt : starve_cnt + STARVE_W'(1);
      else
        starve_cnt <= '0;

      bus.vid_valid <= vid_ret;
      if (vid_ret) bus.vid_rdata <= bus.mem_rdata;

      bus.cpu_ack <= 1'b0;
      case (state)
        C_IDLE: begin
          if (cpu_gnt) begin
            if (bus.cpu_we) begin
              state       <= C_ACK;
              bus.cpu_ack <= 1'b1;
            end else begin
              state <= C_BUSY;
            end
          end
        end
        C_BUSY: begin
          if (cpu_ret) begin
            state         <= C_ACK;
            bus.cpu_ack   <= 1'b1;
            bus.cpu_rdata <= bus.mem_rdata;
          end
        end
        C_ACK:   state <= C_IDLE;
        default: state <= C_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter: RD_LAT=1 instance for timing, RD_LAT=3 instance for a mixed sweep.
module tb_vram_arbiter;
  import vram_arbiter_pkg::*;

  localparam int unsigned AW    = 14;
  localparam int unsigned DW    = 8;
  localparam int unsigned MSIZE = 16384;

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } cpu_t;

  logic clk = 1'b0;
  logic reset_n;
  logic mem_init;
  int   n_assert = 0;
  int   n_fail   = 0;
  int   g3 = 0, r3 = 0;

  always #5 clk = ~clk;

  vram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) b1 ();
  vram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) b3 ();

  vram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(1), .STARVE_MAX(4)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .bus(b1));
  vram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(3), .STARVE_MAX(4)) u_dut3 (
    .clk(clk), .reset_n(reset_n), .bus(b3));

  function automatic logic [DW-1:0] pat(input int i);
    return DW'(i * 7 + 3);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // VRAM models: RD_LAT=1 and RD_LAT=3, X when no read is in flight
  logic [DW-1:0] mem1 [MSIZE];
  logic [DW-1:0] mem3 [MSIZE];
  logic [DW-1:0] d3 [3];

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < int'(MSIZE); i++) mem1[i] <= pat(i);
    end else if (b1.mem_en && b1.mem_we) begin
      mem1[b1.mem_addr] <= b1.mem_wdata;
    end
    b1.mem_rdata <= (b1.mem_en && !b1.mem_we) ? mem1[b1.mem_addr] : 'x;
  end

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < int'(MSIZE); i++) mem3[i] <= pat(i);
    end else if (b3.mem_en && b3.mem_we) begin
      mem3[b3.mem_addr] <= b3.mem_wdata;
    end
    d3[0] <= (b3.mem_en && !b3.mem_we) ? mem3[b3.mem_addr] : 'x;
    d3[1] <= d3[0];
    d3[2] <= d3[1];
  end
  assign b3.mem_rdata = d3[2];

  // Scoreboards: reference memory updated on CPU write completion, video expectations queued at grant
  logic [DW-1:0] ref1 [MSIZE];
  logic [DW-1:0] ref3 [MSIZE];
  cpu_t          cq1[$], cq3[$];
  logic [DW-1:0] vq1[$], vq3[$];
  cpu_t          c1, c3;

  always @(negedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < int'(MSIZE); i++) ref1[i] = pat(i);
    end else if (reset_n) begin
      if (b1.cpu_ack) begin
        if (cq1.size() == 0) chk("cpu1_unexpected_ack", 32'(1), 32'(0));
        else begin
          c1 = cq1.pop_front();
          if (c1.we) ref1[c1.addr] = c1.data;
          else chk("cpu1_rdata", 32'(b1.cpu_rdata), 32'(ref1[c1.addr]));
        end
      end
      if (b1.vid_valid) begin
        if (vq1.size() == 0) chk("vid1_unexpected_valid", 32'(1), 32'(0));
        else chk("vid1_rdata", 32'(b1.vid_rdata), 32'(vq1.pop_front()));
      end
      if (b1.vid_gnt) vq1.push_back(ref1[b1.vid_addr]);
    end
  end

  always @(negedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < int'(MSIZE); i++) ref3[i] = pat(i);
    end else if (reset_n) begin
      if (b3.cpu_ack) begin
        if (cq3.size() == 0) chk("cpu3_unexpected_ack", 32'(1), 32'(0));
        else begin
          c3 = cq3.pop_front();
          if (c3.we) ref3[c3.addr] = c3.data;
          else chk("cpu3_rdata", 32'(b3.cpu_rdata), 32'(ref3[c3.addr]));
        end
      end
      if (b3.vid_valid) begin
        r3++;
        if (vq3.size() == 0) chk("vid3_unexpected_valid", 32'(1), 32'(0));
        else chk("vid3_rdata", 32'(b3.vid_rdata), 32'(vq3.pop_front()));
      end
      if (b3.vid_gnt) begin
        g3++;
        vq3.push_back(ref3[b3.vid_addr]);
      end
      if (b3.mem_en && b3.mem_we && !b3.cpu_ack) chk("vid3_write_without_cpu_ack", 32'(1), 32'(0));
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int   hold;
    logic ack_seen;
    reset_n  = 1'b0;
    mem_init = 1'b1;
    b1.cpu_req = 1'b0; b1.cpu_we = 1'b0; b1.cpu_addr = '0; b1.cpu_wdata = '0;
    b1.vid_req = 1'b0; b1.vid_addr = '0;
    b3.cpu_req = 1'b0; b3.cpu_we = 1'b0; b3.cpu_addr = '0; b3.cpu_wdata = '0;
    b3.vid_req = 1'b0; b3.vid_addr = '0;
    repeat (3) tick();
    mem_init = 1'b0;
    @(negedge clk);
    chk("rst_mem_en",    32'(b1.mem_en),    32'(0));
    chk("rst_mem_we",    32'(b1.mem_we),    32'(0));
    chk("rst_mem_addr",  32'(b1.mem_addr),  32'(0));
    chk("rst_mem_wdata", 32'(b1.mem_wdata), 32'(0));
    chk("rst_cpu_ack",   32'(b1.cpu_ack),   32'(0));
    chk("rst_cpu_rdata", 32'(b1.cpu_rdata), 32'(0));
    chk("rst_vid_valid", 32'(b1.vid_valid), 32'(0));
    chk("rst_vid_rdata", 32'(b1.vid_rdata), 32'(0));
    chk("rst_vid_gnt",   32'(b1.vid_gnt),   32'(0));
    chk("rst3_outputs",  32'({b3.mem_en, b3.cpu_ack, b3.vid_valid}), 32'(0));
    tick();
    reset_n = 1'b1;
    repeat (2) tick();

    // CPU write with idle video: command and ack both in cycle 1
    for (int c = 0; c <= 2; c++) begin
      if (c > 0) tick();
      b1.cpu_req = (c <= 1);
      if (c == 0) begin
        b1.cpu_we = 1'b1; b1.cpu_addr = AW'(14'h0123); b1.cpu_wdata = 8'h5A;
        cq1.push_back('{1'b1, AW'(14'h0123), 8'h5A});
      end
      @(negedge clk);
      chk("wr_ack",    32'(b1.cpu_ack), 32'(c == 1));
      chk("wr_mem_en", 32'(b1.mem_en),  32'(c == 1));
      chk("wr_mem_we", 32'(b1.mem_we),  32'(c == 1));
      if (c == 1) begin
        chk("wr_mem_addr",  32'(b1.mem_addr),  32'h0123);
        chk("wr_mem_wdata", 32'(b1.mem_wdata), 32'h5A);
      end
    end
    repeat (2) tick();

    // CPU read with idle video: ack in cycle 3, no reissue while req is held
    for (int c = 0; c <= 4; c++) begin
      tick();
      b1.cpu_req = (c <= 3);
      if (c == 0) begin
        b1.cpu_we = 1'b0; b1.cpu_addr = AW'(14'h0123);
        cq1.push_back('{1'b0, AW'(14'h0123), 8'h00});
      end
      @(negedge clk);
      chk("rd_ack",    32'(b1.cpu_ack), 32'(c == 3));
      chk("rd_mem_en", 32'(b1.mem_en),  32'(c == 1));
      if (c == 1) chk("rd_mem_addr", 32'(b1.mem_addr), 32'h0123);
      if (c >= 3) chk("rd_cpu_rdata", 32'(b1.cpu_rdata), 32'h5A);
    end
    repeat (2) tick();

    // Continuous video stream: vid_valid continuous from cycle 3, data in address order
    for (int c = 0; c <= 12; c++) begin
      tick();
      b1.vid_req  = (c < 10);
      b1.vid_addr = AW'(c);
      @(negedge clk);
      chk("stream_gnt",    32'(b1.vid_gnt),   32'(c < 10));
      chk("stream_valid",  32'(b1.vid_valid), 32'(c >= 3));
      chk("stream_mem_we", 32'(b1.mem_we),    32'(0));
    end
    repeat (2) tick();
    chk("stream_drained", 32'(vq1.size()), 32'(0));

    // Starvation: CPU read wins in cycle 4 against continuous video
    for (int c = 0; c <= 9; c++) begin
      tick();
      b1.vid_req  = 1'b1;
      b1.vid_addr = AW'(16'h0100 + c);
      b1.cpu_req  = (c <= 7);
      if (c == 0) begin
        b1.cpu_we = 1'b0; b1.cpu_addr = AW'(14'h0123);
        cq1.push_back('{1'b0, AW'(14'h0123), 8'h00});
      end
      @(negedge clk);
      chk("starve_vid_gnt", 32'(b1.vid_gnt), 32'(c != 4));
      chk("starve_ack",     32'(b1.cpu_ack), 32'(c == 7));
      if (c == 5) chk("starve_mem_addr", 32'({b1.mem_en, b1.mem_we, b1.mem_addr}), 32'({2'b10, 14'h0123}));
    end
    b1.vid_req = 1'b0;
    repeat (5) tick();
    chk("starve_drained", 32'(vq1.size() + cq1.size()), 32'(0));

    // Same-address CPU write under starvation: later video reads see the new data
    for (int c = 0; c <= 9; c++) begin
      tick();
      b1.vid_req  = 1'b1;
      b1.vid_addr = AW'(14'h0200);
      b1.cpu_req  = (c <= 5);
      if (c == 0) begin
        b1.cpu_we = 1'b1; b1.cpu_addr = AW'(14'h0200); b1.cpu_wdata = 8'hC3;
        cq1.push_back('{1'b1, AW'(14'h0200), 8'hC3});
      end
      @(negedge clk);
      chk("wrraw_vid_gnt", 32'(b1.vid_gnt), 32'(c != 4));
      chk("wrraw_ack",     32'(b1.cpu_ack), 32'(c == 5));
    end
    b1.vid_req = 1'b0;
    repeat (5) tick();
    chk("wrraw_new_data", 32'(b1.vid_rdata), 32'hC3);

    // Reset with video reads in flight: nothing returns afterwards, then normal latency
    for (int c = 0; c <= 9; c++) begin
      tick();
      b1.vid_req  = (c <= 1) || (c == 6);
      b1.vid_addr = AW'(16'h0010 + c);
      reset_n     = (c != 2);
      if (c == 2) vq1.delete();
      @(negedge clk);
      if (c == 3) begin
        chk("rst2_mem", 32'({b1.mem_en, b1.mem_we, b1.mem_addr}), 32'(0));
        chk("rst2_out", 32'({b1.cpu_ack, b1.vid_rdata, b1.cpu_rdata}), 32'(0));
      end
      if (c >= 3) chk("rst2_vid_valid", 32'(b1.vid_valid), 32'(c == 9));
    end
    b1.vid_req = 1'b0;
    repeat (3) tick();
    chk("rst2_drained", 32'(vq1.size()), 32'(0));

    // RD_LAT=3 mixed random traffic against the reference memory
    ack_seen = 1'b0;
    hold     = 0;
    for (int c = 0; c < 420; c++) begin
      tick();
      b3.vid_req  = (c < 380) && ($urandom_range(0, 3) != 0);
      b3.vid_addr = AW'($urandom_range(0, 31));
      if (ack_seen) begin
        b3.cpu_req = 1'b0;
        ack_seen   = 1'b0;
      end else if (!b3.cpu_req && (c < 380) && ($urandom_range(0, 2) == 0)) begin
        b3.cpu_we    = 1'($urandom_range(0, 1));
        b3.cpu_addr  = AW'($urandom_range(0, 31));
        b3.cpu_wdata = DW'($urandom_range(0, 255));
        b3.cpu_req   = 1'b1;
        hold         = 0;
        cq3.push_back('{b3.cpu_we, b3.cpu_addr, b3.cpu_wdata});
      end else if (b3.cpu_req) begin
        hold++;
        if (hold > 40) begin
          chk("sweep_cpu_ack_timeout", 32'(1), 32'(0));
          b3.cpu_req = 1'b0;
          break;
        end
      end
      @(negedge clk);
      ack_seen = b3.cpu_ack;
    end
    b3.vid_req = 1'b0;
    b3.cpu_req = 1'b0;
    repeat (8) tick();
    chk("sweep_cpu_drained", 32'(cq3.size()), 32'(0));
    chk("sweep_vid_drained", 32'(vq3.size()), 32'(0));
    chk("sweep_resp_eq_gnt", 32'(r3), 32'(g3));
    chk("sweep_enough_traffic", 32'(r3 > 100), 32'(1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/vram_arbiter.md
Name: vram_arbiter

Overview:
Shares the single-port video RAM (CPU window 0xA000-0xDFFF) between two requesters: the chroni display fetch and the CPU bus.
- Video fetch is real-time and has priority; a starvation counter guarantees CPU forward progress.
- Sits between the top-level address decode (vram_cs) and the VRAM macro.
- Issues at most one memory command per cycle and returns read data in order, tagged by owner.

Parameters:
ADDR_W, 14, VRAM word address width (16 KB window)
DATA_W, 8, data width
RD_LAT, 1, VRAM read latency: command on port in cycle T, mem_rdata valid in T+RD_LAT (1..4)
STARVE_MAX, 4, number of consecutive lost CPU arbitration cycles after which the CPU wins (1..15)

Ports:
clk  in  1  system clock
reset_n  in  1  synchronous active-low reset
cpu_req  in  1  CPU access request; held until cpu_ack, dropped the cycle after ack
cpu_we  in  1  1=write, 0=read; stable while cpu_req
cpu_addr  in  ADDR_W  CPU word address (offset within window)
cpu_wdata  in  DATA_W  write data
cpu_rdata  out  DATA_W  read data, valid while cpu_ack=1 on a read
cpu_ack  out  1  one-cycle completion pulse
vid_req  in  1  video fetch request (may be asserted every cycle)
vid_addr  in  ADDR_W  video fetch address
vid_gnt  out  1  combinational: vid_req accepted this cycle
vid_rdata  out  DATA_W  video read data
vid_valid  out  1  vid_rdata valid (one pulse per granted request, in order)
mem_en  out  1  memory command valid
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data

Behaviour:
- Reset (synchronous, reset_n=0 at clk edge): all outputs 0, CPU FSM=C_IDLE, starve_cnt=0, read-tag pipeline cleared; in-flight reads are discarded (no vid_valid/cpu_ack afterwards).
- Arbitration (combinational, cycle N):
  - cpu_elig = cpu_req && state==C_IDLE.
  - CPU granted if cpu_elig && (!vid_req || starve_cnt==STARVE_MAX).
  - Else video granted if vid_req (vid_gnt=1).
  - Neither requesting: no command.
- Command register: mem_en/we/addr/wdata registered from the winner, presented in cycle N+1. mem_we=1 only for a CPU write. Idle cycles drive mem_en=0, mem_we=0.
- starve_cnt: +1 (saturating at STARVE_MAX) when cpu_elig and not granted. Cleared on CPU grant or when !cpu_elig.
- Read-tag pipeline: shift register of depth RD_LAT+1 carrying {valid, owner}, entered at grant.
  - Video tag returns: vid_rdata <= mem_rdata, vid_valid=1 in cycle N+RD_LAT+2.
  - CPU tag returns: cpu_rdata <= mem_rdata, cpu_ack=1 in cycle N+RD_LAT+2.
- CPU FSM:
  - C_IDLE -> C_BUSY on read grant.
  - C_IDLE -> C_ACK on write grant (ack in N+1, same cycle as mem_we).
  - C_BUSY -> C_ACK when the CPU tag returns.
  - C_ACK -> C_IDLE after one cycle.
  - The CPU is ineligible in C_BUSY and C_ACK, so a held cpu_req is never double-issued. One CPU transaction outstanding maximum.
- Video may have RD_LAT+1 reads in flight; results return strictly in grant order.
- cpu_rdata holds its last value outside ack; vid_rdata holds its last value when vid_valid=0.
- Simultaneous CPU write and video read to the same address, starve case: the CPU write is issued first, and a later video read returns the new data (single port, program order).
- cpu_req dropped while in C_BUSY: the transaction still completes and cpu_ack still pulses.

Decomposition:
- Shared header vram_arb.vh (alongside chroni.vh): owner encoding OWN_VID=1'b0, OWN_CPU=1'b1; CPU FSM state codes C_IDLE/C_BUSY/C_ACK; default RD_LAT/STARVE_MAX.
- One sub-module: vram_rd_pipe, the parameterised {valid, owner} shift register of depth RD_LAT+1 with synchronous clear.

Test Plan:
- Idle video, CPU write addr 0x0123 data 0x5A at cycle 0 -> mem_en=1, mem_we=1, mem_addr=0x0123, mem_wdata=0x5A in cycle 1; cpu_ack=1 in cycle 1 only.
- Idle video, CPU read 0x0123 (memory holds 0x5A), RD_LAT=1 -> mem_en=1, mem_we=0 in cycle 1; cpu_ack=1 with cpu_rdata=0x5A in cycle 3; no reissue while cpu_req is held through cycle 3.
- vid_req every cycle, addresses 0x0000,0x0001,... -> vid_valid continuous from cycle 3 with data in address order; mem_we never 1.
- vid_req continuous, CPU read at cycle 0, STARVE_MAX=4 -> vid_gnt=1 in cycles 0-3, vid_gnt=0 and CPU granted in cycle 4; mem_addr=CPU address in cycle 5; cpu_ack in cycle 7; vid_gnt=1 again from cycle 5.
- Video reads granted in cycles 0-1, reset_n=0 in cycle 2 -> all outputs 0 from cycle 3; no vid_valid after reset; first request after release gets normal latency.
- RD_LAT=3 sweep with mixed CPU/video traffic -> every grant yields exactly one response, in order, with matching owner; scoreboard compares against a reference memory model.
